// File: rtl/fb_write_arbiter.sv
// Frame buffer write-port arbiter: pixel stream > clear engine > loader.
// One registered write per cycle onto BRAM port A.
module fb_write_arbiter #(
  parameter int unsigned DEPTH          = 49152,
  parameter logic [11:0] BG_COLOR       = 12'h000,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic [8:0]  x,
  input  logic [8:0]  y,
  input  logic [11:0] color,
  input  logic        pix_en,
  input  logic        clear_start,
  input  logic [11:0] clear_color,
  output logic        clear_busy,
  output logic        clear_done,
  input  logic        req_valid,
  input  logic [15:0] req_addr,
  input  logic [11:0] req_data,
  output logic        req_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [11:0] mem_wdata
);

  localparam logic [15:0] LastAddr = 16'(DEPTH - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [11:0] fill_q, fill_d;
  logic        init_q;

  logic        pix_hit;
  logic        start;
  logic [11:0] start_color;
  logic        clr_wr;
  logic        ld_wr;
  logic        we_d;
  logic [15:0] addr_d;
  logic [11:0] wdata_d;
  logic        done_d;

  // The pending post-reset clear behaves exactly like an external clear_start.
  assign start       = clear_start | init_q;
  assign start_color = init_q ? BG_COLOR : clear_color;

  // State, counter, latched colour and registered write port.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      fill_q     <= '0;
      init_q     <= CLEAR_ON_RESET;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      clear_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      init_q     <= 1'b0;
      mem_we     <= we_d;
      clear_done <= done_d;
      if (we_d) begin
        mem_addr  <= addr_d;
        mem_wdata <= wdata_d;
      end
    end
  end

  // Next-state: (re)start a clear, or advance the clear on cycles the pixel stream leaves free.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fill_d  = fill_q;
    if (start) begin
      state_d = StClear;
      cnt_d   = '0;
      fill_d  = start_color;
    end else if (clr_wr) begin
      if (cnt_q == LastAddr) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
    end
  end

  // Outputs: fixed-priority write select and loader handshake.
  always_comb begin
    pix_hit = ce_pix & pix_en & (y < 9'd192) & (x != 9'd0) & (x <= 9'd256);
    // The restart cycle itself issues no clear write; the first one follows a cycle later.
    clr_wr  = (state_q == StClear) & ~pix_hit & ~start;
    req_ready = ~reset & (state_q == StIdle) & ~pix_hit & ~start;
    // Out-of-range loader addresses complete the handshake but are dropped.
    ld_wr   = req_valid & req_ready & (32'(req_addr) < DEPTH);
    we_d    = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    if (pix_hit) begin
      we_d    = 1'b1;
      addr_d  = {y[7:0], x[7:0] - 8'd1};
      wdata_d = color;
    end else if (clr_wr) begin
      we_d    = 1'b1;
      addr_d  = cnt_q;
      wdata_d = fill_q;
    end else if (ld_wr) begin
      we_d    = 1'b1;
      addr_d  = req_addr;
      wdata_d = req_data;
    end
    done_d     = clr_wr & (cnt_q == LastAddr);
    clear_busy = (state_q == StClear);
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Bench for fb_write_arbiter: dut0 uses full-size buffer with auto-clear,
// dut1 a 4096-entry buffer without auto-clear for the clear-engine scenarios.
module tb_fb_write_arbiter;

  logic        clk = 1'b0;
  logic        rst0, rst1;
  logic        ce_pix, pix_en, clear_start, req_valid;
  logic [8:0]  x, y;
  logic [11:0] color, clear_color, req_data;
  logic [15:0] req_addr;

  logic        busy0, done0, rdy0, we0;
  logic [15:0] addr0;
  logic [11:0] wdata0;
  logic        busy1, done1, rdy1, we1;
  logic [15:0] addr1;
  logic [11:0] wdata1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fb_write_arbiter #(.DEPTH(49152), .BG_COLOR(12'h321), .CLEAR_ON_RESET(1'b1)) dut0 (
    .clk(clk), .reset(rst0), .ce_pix(ce_pix), .x(x), .y(y), .color(color), .pix_en(pix_en),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(busy0),
    .clear_done(done0), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0)
  );

  fb_write_arbiter #(.DEPTH(4096), .BG_COLOR(12'h000), .CLEAR_ON_RESET(1'b0)) dut1 (
    .clk(clk), .reset(rst1), .ce_pix(ce_pix), .x(x), .y(y), .color(color), .pix_en(pix_en),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(busy1),
    .clear_done(done1), .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle pixel strobe on both DUTs' shared inputs.
  task automatic pix(input logic [8:0] px, input logic [8:0] py, input logic [11:0] c,
                     input logic en);
    ce_pix = 1'b1; pix_en = en; x = px; y = py; color = c;
    step();
    ce_pix = 1'b0; pix_en = 1'b1;
  endtask

  initial begin
    int bad_we, bad_done, bad_busy, cyc, ndone, done_addr, bad;
    rst0 = 1'b1; rst1 = 1'b1;
    ce_pix = 1'b0; pix_en = 1'b1; x = '0; y = '0; color = '0;
    clear_start = 1'b0; clear_color = '0;
    req_valid = 1'b0; req_addr = '0; req_data = '0;
    repeat (3) step();

    // Reset state
    check("rst_we0", 32'(we0), 0);
    check("rst_addr0", 32'(addr0), 0);
    check("rst_wdata0", 32'(wdata0), 0);
    check("rst_busy0", 32'(busy0), 0);
    check("rst_done0", 32'(done0), 0);
    check("rst_rdy1", 32'(rdy1), 0);

    // Automatic clear after reset with BG_COLOR 321
    rst0 = 1'b0;
    step();
    check("rc_busy_rise", 32'(busy0), 1);
    check("rc_we_first", 32'(we0), 0);
    bad_we = 0; bad_done = 0; bad_busy = 0;
    for (int i = 0; i < 49152; i++) begin
      step();
      if (!we0 || addr0 != 16'(i) || wdata0 != 12'h321) bad_we++;
      if (done0 != (i == 49151)) bad_done++;
      if (busy0 != (i != 49151)) bad_busy++;
    end
    check("rc_writes", 32'(bad_we), 0);
    check("rc_done_pulse", 32'(bad_done), 0);
    check("rc_busy", 32'(bad_busy), 0);
    check("rc_last_addr", 32'(addr0), 49151);
    step();
    check("rc_after_we", 32'(we0), 0);
    check("rc_after_done", 32'(done0), 0);

    // Pixel mapping
    pix(9'd1, 9'd0, 12'hABC, 1'b1);
    check("px_first_we", 32'(we0), 1);
    check("px_first_addr", 32'(addr0), 0);
    check("px_first_data", 32'(wdata0), 32'h0ABC);
    pix(9'd256, 9'd191, 12'h123, 1'b1);
    check("px_last_addr", 32'(addr0), 49151);
    check("px_last_data", 32'(wdata0), 32'h0123);
    pix(9'd0, 9'd10, 12'h777, 1'b1);
    check("px_x0_we", 32'(we0), 0);
    check("px_hold_addr", 32'(addr0), 49151);
    pix(9'd257, 9'd10, 12'h777, 1'b1);
    check("px_x257_we", 32'(we0), 0);
    pix(9'd5, 9'd192, 12'h777, 1'b1);
    check("px_y192_we", 32'(we0), 0);
    pix(9'd5, 9'd5, 12'h777, 1'b0);
    check("px_freeze_we", 32'(we0), 0);

    // Loader handshake, with a pixel colliding on the first cycle
    req_valid = 1'b1; req_addr = 16'd5; req_data = 12'h005;
    ce_pix = 1'b1; x = 9'd3; y = 9'd0; color = 12'h333;
    #1 check("ld_rdy_pix", 32'(rdy0), 0);
    step();
    ce_pix = 1'b0;
    check("ld_pix_addr", 32'(addr0), 2);
    #1 check("ld_rdy_free", 32'(rdy0), 1);
    for (int i = 5; i <= 7; i++) begin
      req_addr = 16'(i); req_data = 12'(i);
      step();
      check("ld_we", 32'(we0), 1);
      check("ld_addr", 32'(addr0), 32'(i));
      check("ld_data", 32'(wdata0), 32'(i));
    end
    req_addr = 16'd50000; req_data = 12'hEEE;
    #1 check("ld_oob_rdy", 32'(rdy0), 1);
    step();
    check("ld_oob_we", 32'(we0), 0);
    req_valid = 1'b0;

    // Switch to dut1 (DEPTH 4096, no auto-clear)
    rst0 = 1'b1; rst1 = 1'b0;
    step();
    check("d1_idle_busy", 32'(busy1), 0);
    check("d1_idle_we", 32'(we1), 0);

    // Pixel + clear_start + loader in the same idle cycle
    ce_pix = 1'b1; x = 9'd2; y = 9'd0; color = 12'h111;
    clear_start = 1'b1; clear_color = 12'hFFF;
    req_valid = 1'b1; req_addr = 16'd9; req_data = 12'h999;
    #1 check("tri_rdy", 32'(rdy1), 0);
    step();
    ce_pix = 1'b0; clear_start = 1'b0; req_valid = 1'b0;
    check("tri_addr", 32'(addr1), 1);
    check("tri_data", 32'(wdata1), 32'h0111);
    check("tri_busy", 32'(busy1), 1);

    // Pixel during clear, on clear step 100
    bad = 0;
    for (int k = 1; k <= 100; k++) begin
      step();
      if (!we1 || addr1 != 16'(k - 1) || wdata1 != 12'hFFF) bad++;
    end
    check("pc_steps", 32'(bad), 0);
    pix(9'd10, 9'd5, 12'h0A0, 1'b1);
    check("pc_pix_addr", 32'(addr1), 1289);
    check("pc_pix_data", 32'(wdata1), 32'h00A0);
    step();
    check("pc_resume_addr", 32'(addr1), 100);
    check("pc_resume_data", 32'(wdata1), 32'h0FFF);
    cyc = 102;
    while (!done1 && cyc < 6000) begin
      step();
      cyc++;
    end
    check("pc_length", 32'(cyc), 4097);
    check("pc_done_addr", 32'(addr1), 4095);
    check("pc_done_busy", 32'(busy1), 0);
    step();

    // Restart at cnt 2000
    clear_start = 1'b1; clear_color = 12'h5A5;
    step();
    clear_start = 1'b0;
    repeat (2000) step();
    check("rs_pre_addr", 32'(addr1), 1999);
    clear_start = 1'b1; clear_color = 12'h0F0;
    step();
    clear_start = 1'b0;
    check("rs_gap_we", 32'(we1), 0);
    step();
    check("rs_first_addr", 32'(addr1), 0);
    check("rs_first_data", 32'(wdata1), 32'h00F0);
    ndone = 0; done_addr = 0;
    for (int i = 0; i < 4200; i++) begin
      step();
      if (done1) begin
        ndone++;
        done_addr = 32'(addr1);
      end
    end
    check("rs_done_count", 32'(ndone), 1);
    check("rs_done_addr", 32'(done_addr), 4095);

    // Reset asserted mid-clear
    clear_start = 1'b1; clear_color = 12'h777;
    step();
    clear_start = 1'b0;
    repeat (50) step();
    check("ab_busy_mid", 32'(busy1), 1);
    rst1 = 1'b1;
    step();
    check("ab_we", 32'(we1), 0);
    check("ab_busy", 32'(busy1), 0);
    check("ab_done", 32'(done1), 0);
    rst1 = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done1 || we1 || busy1) bad++;
    end
    check("ab_quiet", 32'(bad), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
